// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front end.
//   FRAME_W / DATA_W : command-word and read-data widths
//   OP_*             : opcode values carried in frame bits [9:8]
//   state_t          : frame-handling FSM states
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

endpackage

// File: rtl/spi_slave_if_if.sv
// spi_slave_if_if: SPI pins plus the parallel handshake toward the memory block.
//   SS_n, MOSI, MISO   : serial side (sampled on the system clock)
//   rx_data, rx_valid  : completed command word and its one-cycle strobe
//   tx_data, tx_valid  : read byte from memory and its qualifier
//   modport slave      : the SPI front end
//   modport master     : the SPI master + memory side (testbench)
interface spi_slave_if_if;
    import spi_pkg::*;

    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: parallel-load, MSB-first serialiser for read data.
//   clk, rst_n : system clock, async active-low reset
//   i_load     : capture i_data; first bit appears on o_serial one edge later
//   i_data     : byte to send
//   i_abort    : drop any transfer in progress, force o_serial low
//   o_serial   : serial output, 0 when idle
//   o_busy     : transfer in progress
module spi_tx_shifter
    import spi_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_abort,
    output logic         o_serial,
    output logic         o_busy
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_serial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_serial <= 1'b0;
        end else if (i_abort) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_serial <= 1'b0;
        end else if (i_load) begin
            r_shift  <= i_data;
            r_cnt    <= CNT_W'(W);
            r_serial <= 1'b0;
        end else if (r_cnt != '0) begin
            r_serial <= r_shift[W-1];
            r_shift  <= {r_shift[W-2:0], 1'b0};
            r_cnt    <= r_cnt - CNT_W'(1);
        end else begin
            r_serial <= 1'b0;
        end
    end

    assign o_serial = r_serial;
    assign o_busy   = (r_cnt != '0);

endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end for the SPI-to-RAM memory block.
//   clk, rst_n : system clock, async active-low reset
//   bus        : spi_slave_if_if.slave (SS_n, MOSI, MISO, rx_data, rx_valid,
//                tx_data, tx_valid)
// Deserialises one 10-bit frame per SS_n assertion; on read-data frames waits
// for tx_valid and shifts the returned byte out on MISO.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | SS_n high or waiting for it to fall
//   CHK_CMD   | sample frame bit 9, pick the frame type
//   WRITE     | shift bits 8..0 of a write frame, then ignore MOSI
//   READ_ADD  | shift bits 8..0 of a read-address frame, then ignore MOSI
//   READ_DATA | shift bits 8..0, then wait for tx_valid and drive MISO
module spi_slave_if
    import spi_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    spi_slave_if_if.slave bus
);

    localparam int CNT_W = $clog2(FRAME_W - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FRAME_W-2:0] r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_frame_done;
    logic               r_tx_loaded;
    logic               r_rd_addr_seen;
    logic [FRAME_W-1:0] r_rx_data;
    logic               r_rx_valid;

    logic w_in_frame;
    logic w_last_bit;
    logic w_tx_load;
    logic w_tx_busy;
    logic w_miso;

    // Shifting states double as "frame received" states once r_frame_done is set.
    assign w_in_frame = (r_state inside {WRITE, READ_ADD, READ_DATA}) &&
                        !r_frame_done && !bus.SS_n;
    assign w_last_bit = w_in_frame && (r_bit_cnt == '0);
    assign w_tx_load  = (r_state == READ_DATA) && r_frame_done && !r_tx_loaded &&
                        !w_tx_busy && !bus.SS_n && bus.tx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.SS_n) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = CHK_CMD;
                CHK_CMD: begin
                    if (!bus.MOSI)          w_state_nxt = WRITE;
                    else if (r_rd_addr_seen) w_state_nxt = READ_DATA;
                    else                    w_state_nxt = READ_ADD;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_frame_done   <= 1'b0;
            r_tx_loaded    <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (bus.SS_n) begin
                r_frame_done <= 1'b0;
                r_tx_loaded  <= 1'b0;
            end else begin
                if (r_state == CHK_CMD) begin
                    r_shift   <= {{(FRAME_W-2){1'b0}}, bus.MOSI};
                    r_bit_cnt <= CNT_W'(FRAME_W - 2);
                end
                if (w_in_frame) begin
                    r_shift <= {r_shift[FRAME_W-3:0], bus.MOSI};
                    if (w_last_bit) begin
                        r_rx_data    <= {r_shift, bus.MOSI};
                        r_rx_valid   <= 1'b1;
                        r_frame_done <= 1'b1;
                        if (r_state == READ_ADD)  r_rd_addr_seen <= 1'b1;
                        if (r_state == READ_DATA) r_rd_addr_seen <= 1'b0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                    end
                end
                if (w_tx_load) begin
                    r_tx_loaded <= 1'b1;
                end
            end
        end
    end

    spi_tx_shifter #(.W(DATA_W)) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_tx_load),
        .i_data   (bus.tx_data),
        .i_abort  (bus.SS_n),
        .o_serial (w_miso),
        .o_busy   (w_tx_busy)
    );

    assign bus.MISO     = w_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
module tb_spi_slave_if;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_slave_if_if bus ();

    spi_slave_if dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: last forwarded frame, read-address flag, memory contents.
    logic [9:0] m_rx;
    bit         m_seen;
    logic [7:0] m_mem [256];
    logic [7:0] m_wr_addr;
    logic [7:0] m_rd_addr;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_rx = '0;
        m_seen = 1'b0;
    endtask

    task automatic model_frame(input logic [9:0] f);
        m_rx = f;
        case (f[9:8])
            OP_WR_ADDR: m_wr_addr = f[7:0];
            OP_WR_DATA: m_mem[m_wr_addr] = f[7:0];
            OP_RD_ADDR: m_rd_addr = f[7:0];
            default: ;
        endcase
    endtask

    // One full transaction. cut_bits > 0: stop after that many MISO bits,
    // by reset (cut_rst) or by raising SS_n.
    task automatic run_frame(input logic [9:0] f, input int tx_delay, input bit junk_tx,
                             input int cut_bits, input bit cut_rst);
        logic [9:0] prev;
        bit         rd_data;
        logic [7:0] rbyte;
        state_t     exp_st;
        prev    = m_rx;
        rd_data = f[9] && m_seen;
        exp_st  = !f[9] ? WRITE : (m_seen ? READ_DATA : READ_ADD);

        bus.SS_n = 1'b0;
        bus.MOSI = 1'($urandom);
        step();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = f[i];
            if (i == 0 && junk_tx) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'($urandom);
            end
            step();
            bus.tx_valid = 1'b0;
            if (i == 9) chk_val("state_after_cmd", 32'(dut.r_state), 32'(exp_st));
            if (i > 0) begin
                chk_val("rx_valid_mid", 32'(bus.rx_valid), 32'd0);
                chk_val("rx_data_hold", 32'(bus.rx_data), 32'(prev));
            end
        end
        chk_val("rx_valid_done", 32'(bus.rx_valid), 32'd1);
        chk_val("rx_data_done", 32'(bus.rx_data), 32'(f));
        if (f[9]) m_seen = !rd_data;
        rbyte = m_mem[m_rd_addr];
        model_frame(f);
        chk_val("rd_addr_seen", 32'(dut.r_rd_addr_seen), 32'(m_seen));

        if (rd_data) begin
            for (int d = 0; d < tx_delay; d++) begin
                bus.MOSI = 1'($urandom);
                step();
                chk_val("miso_wait", 32'(bus.MISO), 32'd0);
                chk_val("rx_valid_once", 32'(bus.rx_valid), 32'd0);
            end
            bus.tx_valid = 1'b1;
            bus.tx_data  = rbyte;
            step();
            chk_val("miso_load", 32'(bus.MISO), 32'd0);
            for (int j = 7; j >= 0; j--) begin
                bus.tx_valid = 1'($urandom);
                bus.tx_data  = 8'($urandom);
                bus.MOSI     = 1'($urandom);
                step();
                chk_val("miso_bit", 32'(bus.MISO), 32'(rbyte[j]));
                if (cut_bits > 0 && (8 - j) == cut_bits) begin
                    bus.tx_valid = 1'b0;
                    if (cut_rst) begin
                        #2 rst_n = 1'b0;
                        #1;
                        chk_val("rst_miso", 32'(bus.MISO), 32'd0);
                        chk_val("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
                        chk_val("rst_rx_data", 32'(bus.rx_data), 32'd0);
                        chk_val("rst_seen", 32'(dut.r_rd_addr_seen), 32'd0);
                        chk_val("rst_state", 32'(dut.r_state), 32'(IDLE));
                        model_reset();
                        bus.SS_n = 1'b1;
                        step();
                        rst_n = 1'b1;
                        step();
                    end else begin
                        bus.SS_n = 1'b1;
                        step();
                        chk_val("abort_miso", 32'(bus.MISO), 32'd0);
                        chk_val("abort_state", 32'(dut.r_state), 32'(IDLE));
                    end
                    return;
                end
            end
            bus.tx_valid = 1'b0;
            for (int j = 0; j < 2; j++) begin
                step();
                chk_val("miso_tail", 32'(bus.MISO), 32'd0);
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                bus.MOSI     = 1'($urandom);
                bus.tx_valid = junk_tx;
                bus.tx_data  = 8'($urandom);
                step();
                chk_val("miso_quiet", 32'(bus.MISO), 32'd0);
                chk_val("rx_valid_extra", 32'(bus.rx_valid), 32'd0);
                chk_val("rx_data_stable", 32'(bus.rx_data), 32'(f));
            end
            bus.tx_valid = 1'b0;
        end
        bus.SS_n = 1'b1;
        step();
        chk_val("end_state", 32'(dut.r_state), 32'(IDLE));
        chk_val("end_miso", 32'(bus.MISO), 32'd0);
    endtask

    task automatic abort_frame(input int nbits);
        logic [9:0] prev;
        prev = m_rx;
        bus.SS_n = 1'b0;
        step();
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = 1'($urandom);
            step();
            chk_val("part_rx_valid", 32'(bus.rx_valid), 32'd0);
        end
        bus.SS_n = 1'b1;
        step();
        chk_val("part_rx_valid_end", 32'(bus.rx_valid), 32'd0);
        chk_val("part_rx_data", 32'(bus.rx_data), 32'(prev));
        chk_val("part_state", 32'(dut.r_state), 32'(IDLE));
        chk_val("part_seen", 32'(dut.r_rd_addr_seen), 32'(m_seen));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f;
        int kind;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data = '0;
        for (int a = 0; a < 256; a++) m_mem[a] = '0;
        m_wr_addr = '0;
        m_rd_addr = '0;
        model_reset();

        rst_n = 1'b0;
        step();
        step();
        chk_val("reset_miso", 32'(bus.MISO), 32'd0);
        chk_val("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk_val("reset_rx_data", 32'(bus.rx_data), 32'd0);
        chk_val("reset_seen", 32'(dut.r_rd_addr_seen), 32'd0);
        chk_val("reset_state", 32'(dut.r_state), 32'(IDLE));
        rst_n = 1'b1;
        step();

        run_frame(10'h005, 0, 1'b0, 0, 1'b0);
        run_frame(10'h1AA, 0, 1'b0, 0, 1'b0);
        run_frame(10'h205, 0, 1'b0, 0, 1'b0);
        run_frame(10'h3C3, 0, 1'b1, 0, 1'b0);
        run_frame(10'h317, 0, 1'b1, 0, 1'b0);
        run_frame(10'h3FF, 3, 1'b0, 0, 1'b0);
        abort_frame(5);

        for (int it = 0; it < 60; it++) begin
            kind = int'($urandom_range(0, 6));
            f = 10'($urandom);
            if (kind == 5) abort_frame(int'($urandom_range(1, 9)));
            else if (kind == 6) run_frame(f, int'($urandom_range(0, 3)), 1'b0,
                                          int'($urandom_range(1, 7)), 1'b0);
            else run_frame(f, int'($urandom_range(0, 4)), 1'($urandom), 0, 1'b0);
        end

        run_frame(10'h009, 0, 1'b0, 0, 1'b0);
        run_frame(10'h15A, 0, 1'b0, 0, 1'b0);
        if (m_seen) run_frame(10'h300, 0, 1'b0, 0, 1'b0);
        run_frame(10'h209, 0, 1'b0, 0, 1'b0);
        run_frame(10'h3A5, 0, 1'b0, 4, 1'b1);
        run_frame(10'h2F0, 1, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
